// File: rtl/random_arbiter_pkg.sv
// Shared types and constants for the random arbiter: FSM states, LFSR geometry
// and the Fibonacci feedback polynomial x^16 + x^14 + x^13 + x^11 + 1.
package random_arbiter_pkg;

    localparam int          LFSR_WIDTH   = 16;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        SCALE
    } state_t;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        return {s[LFSR_WIDTH-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    endfunction

endpackage

// File: rtl/random_lfsr16.sv
// Free-running 16-bit LFSR with a free-running cycle counter that is folded into
// the state on each rising edge of the entropy strobe.
module random_lfsr16
    import random_arbiter_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  seed_event,
    output logic [LFSR_WIDTH-1:0] lfsr
);

    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic [LFSR_WIDTH-1:0] r_cnt;
    logic                  r_seed_d;
    logic [LFSR_WIDTH-1:0] w_next;
    logic [LFSR_WIDTH-1:0] w_mixed;

    assign w_next  = lfsr_next(r_lfsr);
    assign w_mixed = w_next ^ r_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_lfsr   <= SEED;
            r_cnt    <= '0;
            r_seed_d <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_seed_d <= seed_event;
            // An all-zero state would lock the LFSR up, so fall back to the seed.
            if (seed_event && !r_seed_d) begin
                r_lfsr <= (w_mixed == '0) ? SEED : w_mixed;
            end else begin
                r_lfsr <= w_next;
            end
        end
    end

    assign lfsr = r_lfsr;

endmodule

// File: rtl/random_arbiter.sv
// Round-robin arbiter that hands out LFSR samples to NUM_REQ requesters, each
// scaled into 0..range_max[i], with a one-cycle ack per grant.
module random_arbiter
    import random_arbiter_pkg::*;
#(
    parameter int                    NUM_REQ   = 4,
    parameter int                    SIZE_BITS = 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                seed_event,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0][SIZE_BITS-1:0]   range_max,
    output logic [NUM_REQ-1:0]                  ack,
    output logic [SIZE_BITS-1:0]                dout,
    output logic [$clog2(NUM_REQ)-1:0]          grant_idx,
    output logic                                busy
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int PW   = 2 * SIZE_BITS + 1;

    state_t                r_state;
    state_t                w_state_next;
    logic [IDXW-1:0]       r_grant;
    logic [IDXW-1:0]       r_ptr;
    logic [SIZE_BITS-1:0]  r_raw_q;
    logic [SIZE_BITS-1:0]  r_dout;
    logic [NUM_REQ-1:0]    r_ack;
    logic [LFSR_WIDTH-1:0] w_lfsr;
    logic                  w_any;
    logic [IDXW-1:0]       w_pick;
    logic [PW-1:0]         w_prod;

    random_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .resetN    (resetN),
        .seed_event(seed_event),
        .lfsr      (w_lfsr)
    );

    // Walk downward so the candidate closest to the pointer is the last one written.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[IDXW'((int'(r_ptr) + k) % NUM_REQ)]) begin
                w_any  = 1'b1;
                w_pick = IDXW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    // (range_max + 1) needs SIZE_BITS+1 bits so the all-ones bound returns raw_q unchanged.
    assign w_prod = PW'(r_raw_q) * (PW'(range_max[r_grant]) + PW'(1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = SAMPLE;
            SAMPLE:  w_state_next = req[r_grant] ? SCALE : IDLE;
            SCALE:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_grant <= '0;
            r_ptr   <= '0;
            r_raw_q <= '0;
            r_dout  <= '0;
            r_ack   <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) r_grant <= w_pick;
                end
                SAMPLE: begin
                    if (req[r_grant]) r_raw_q <= SIZE_BITS'(w_lfsr);
                end
                SCALE: begin
                    r_dout <= SIZE_BITS'(w_prod >> SIZE_BITS);
                    r_ack  <= NUM_REQ'(1) << r_grant;
                    r_ptr  <= (r_grant == IDXW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ack       = r_ack;
    assign dout      = r_dout;
    assign grant_idx = r_grant;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_random_arbiter.sv
// Directed bench for random_arbiter: golden LFSR/counter model plus a scoreboard
// of predicted grants (index, dout, ack cycle) popped as acks arrive.
module tb_random_arbiter;

    localparam logic [15:0] SEED = 16'hACE1;

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic            seed_event = 1'b0;
    logic [3:0]      req = 4'b0000;
    logic [3:0][7:0] range_max;
    logic [3:0]      ack;
    logic [7:0]      dout;
    logic [1:0]      grant_idx;
    logic            busy;

    random_arbiter #(
        .NUM_REQ  (4),
        .SIZE_BITS(8),
        .LFSR_SEED(SEED)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .seed_event(seed_event),
        .req       (req),
        .range_max (range_max),
        .ack       (ack),
        .dout      (dout),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Golden LFSR + entropy counter
    logic [15:0] m_lfsr;
    logic [15:0] m_cnt;
    logic        m_seed_d;
    logic [15:0] m_mix;
    int          cyc = 0;

    assign m_mix = step(m_lfsr) ^ m_cnt;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_lfsr   <= SEED;
            m_cnt    <= 16'd0;
            m_seed_d <= 1'b0;
        end else begin
            m_cnt    <= m_cnt + 16'd1;
            m_seed_d <= seed_event;
            if (seed_event && !m_seed_d) m_lfsr <= (m_mix == 16'd0) ? SEED : m_mix;
            else                         m_lfsr <= step(m_lfsr);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        logic [7:0] d;
        int         at;
    } exp_t;

    exp_t       sb[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         b_ptr = 0;
    logic [7:0] seen = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int next_idx(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        req    = 4'b0000;
        b_ptr  = 0;
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_dout", dout, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_busy", busy, 0);
        resetN = 1'b1;
    endtask

    // Drive req=rv from IDLE and predict n grants; range_max held constant throughout.
    task automatic burst(input logic [3:0] rv, input int n);
        logic [15:0] l;
        int          c0;
        int          w;
        exp_t        e;
        @(negedge clk);
        req = rv;
        c0  = cyc;
        l   = step(m_lfsr);
        for (int k = 0; k < n; k++) begin
            e.idx = next_idx(rv, b_ptr);
            e.d   = 8'((int'(l[7:0]) * (int'(range_max[e.idx]) + 1)) >> 8);
            e.at  = c0 + 3 + 3 * k;
            sb.push_back(e);
            b_ptr = (e.idx + 1) % 4;
            l = step(step(step(l)));
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (ack == 4'b0000 && w < 12);
            chk("ack_cycle", cyc, e.at);
            chk("ack_onehot", ack, 32'd1 << e.idx);
            chk("grant_idx", grant_idx, e.idx);
            chk("dout", dout, e.d);
            if (dout < 8) seen = seen | (8'd1 << dout);
        end
        req = 4'b0000;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] l, x, y;
        int          hit_a, hit_d;
        bit          found;

        range_max = {8'd255, 8'd255, 8'd255, 8'd255};

        // Reset values, then a single grant from the seed state
        do_reset();
        burst(4'b0001, 1);

        // All requesters held: strict round robin 0,1,2,3,0
        do_reset();
        burst(4'b1111, 5);

        // range_max=0 then range_max=5 on requester 2
        range_max[2] = 8'd0;
        burst(4'b0100, 20);
        range_max[2] = 8'd5;
        seen = 8'h00;
        burst(4'b0100, 1000);
        chk("range5_all_values", {24'd0, seen & 8'h3f}, 32'h3f);

        // Withdraw during SAMPLE: no ack, pointer unchanged
        do_reset();
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        chk("wd_busy_sample", busy, 1);
        req = 4'b0000;
        @(negedge clk);
        chk("wd_busy_idle", busy, 0);
        repeat (4) begin
            @(negedge clk);
            chk("wd_no_ack", ack, 0);
        end
        burst(4'b0011, 1);

        // Find a two-edge seed pattern whose second edge would produce an all-zero LFSR
        @(negedge clk);
        found = 1'b0;
        hit_a = 0;
        hit_d = 0;
        l = m_lfsr;
        for (int a = 0; a < 1024 && !found; a++) begin
            x = step(l) ^ (m_cnt + 16'(a));
            if (x == 16'd0) begin
                found = 1'b1;
                hit_a = a;
                hit_d = 0;
            end else begin
                y = x;
                for (int d = 2; d < 1024 && !found; d++) begin
                    y = step(y);
                    if (step(y) == m_cnt + 16'(a + d)) begin
                        found = 1'b1;
                        hit_a = a;
                        hit_d = d;
                    end
                end
            end
            l = step(l);
        end
        if (found) begin
            repeat (hit_a) @(negedge clk);
            seed_event = 1'b1;
            @(negedge clk);
            seed_event = 1'b0;
            if (hit_d > 0) begin
                repeat (hit_d - 1) @(negedge clk);
                seed_event = 1'b1;
                @(negedge clk);
                seed_event = 1'b0;
            end
            chk("seed_zero_fallback", dut.w_lfsr, SEED);
        end else begin
            $display("note: no zero-producing seed pattern found in search window");
        end

        // Random entropy strobes: LFSR tracks the model and never reaches zero
        repeat (20000) begin
            @(negedge clk);
            seed_event = ($urandom_range(0, 3) == 0);
            chk("lfsr_model", dut.w_lfsr, m_lfsr);
            chk("lfsr_nonzero", (dut.w_lfsr != 16'd0), 1);
        end
        @(negedge clk);
        seed_event = 1'b0;
        repeat (3) @(negedge clk);

        // Reset asserted during SCALE
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("scale_busy", busy, 1);
        resetN = 1'b0;
        req    = 4'b0000;
        b_ptr  = 0;
        #1;
        chk("midrst_ack", ack, 0);
        chk("midrst_dout", dout, 0);
        chk("midrst_grant", grant_idx, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        chk("midrst_no_ack", ack, 0);
        resetN = 1'b1;
        burst(4'b0100, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
